// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the integer register file write port
// Registers the winning write one cycle later; writes to x0 handshake normally but are dropped and counted.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_valid,
  input  logic [NUM_REQ*5-1:0]  i_address,
  input  logic [NUM_REQ*32-1:0] i_data,
  output logic [NUM_REQ-1:0]    o_ready,
  output logic                  o_writeEnable,
  output logic [4:0]            o_writeAddress,
  output logic [31:0]           o_writeData,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_x0DropCount
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [4:0]         sel_addr;
  logic [31:0]        sel_data;
  logic               xfer;

  logic               we_q;
  logic [4:0]         waddr_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;

  // Slot i of the search visits requester (ptr+1+i) mod NUM_REQ; the first valid one wins.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    ptr_d    = ptr_q;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && (((int'(ptr_q) + i + 1) % NUM_REQ) == k) && i_valid[k]) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          ptr_d    = PW'(k);
          sel_addr = i_address[k*5 +: 5];
          sel_data = i_data[k*32 +: 32];
        end
      end
    end
  end

  assign xfer = found;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q   <= PW'(NUM_REQ - 1);
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q <= xfer && (sel_addr != 5'd0);
      if (xfer) begin
        ptr_q   <= ptr_d;
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
        // Saturating count of accepted x0 writes.
        if ((sel_addr == 5'd0) && (cnt_q != '1)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign o_ready        = grant;
  assign o_busy         = |(i_valid & ~grant);
  assign o_writeEnable  = we_q;
  assign o_writeAddress = waddr_q;
  assign o_writeData    = wdata_q;
  assign o_x0DropCount  = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  valid;
  logic [9:0]  addr;
  logic [63:0] data;
  logic [1:0]  ready;
  logic        we, busy;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [15:0] cnt;

  logic [1:0]  ready_s;
  logic        we_s, busy_s;
  logic [4:0]  waddr_s;
  logic [31:0] wdata_s;
  logic [1:0]  cnt_s;

  logic [3:0]   valid4;
  logic [19:0]  addr4;
  logic [127:0] data4;
  logic [3:0]   ready4;
  logic         we4, busy4;
  logic [4:0]   waddr4;
  logic [31:0]  wdata4;
  logic [15:0]  cnt4;

  regfile_write_arbiter #(.NUM_REQ(2), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_address(addr), .i_data(data),
    .o_ready(ready), .o_writeEnable(we), .o_writeAddress(waddr), .o_writeData(wdata),
    .o_busy(busy), .o_x0DropCount(cnt));

  regfile_write_arbiter #(.NUM_REQ(2), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_address(addr), .i_data(data),
    .o_ready(ready_s), .o_writeEnable(we_s), .o_writeAddress(waddr_s), .o_writeData(wdata_s),
    .o_busy(busy_s), .o_x0DropCount(cnt_s));

  regfile_write_arbiter #(.NUM_REQ(4), .CNT_W(16)) u_q4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid4), .i_address(addr4), .i_data(data4),
    .o_ready(ready4), .o_writeEnable(we4), .o_writeAddress(waddr4), .o_writeData(wdata4),
    .o_busy(busy4), .o_x0DropCount(cnt4));

  int vectors = 0;
  int miscompares = 0;
  int x0_exp = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called #1 after a posedge; exp_ready/exp_busy are the hand-derived arbitration results.
  task automatic drive(input logic r, input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] exp_ready, input logic exp_busy);
    logic [4:0]  a;
    logic [31:0] d;
    logic [36:0] e;
    rst   = r;
    valid = v;
    addr  = {a1, a0};
    data  = {d1, d0};
    #1;
    check("ready", 64'(ready), 64'(exp_ready));
    check("busy", 64'(busy), 64'(exp_busy));
    if (r) begin
      x0_exp = 0;
    end else if (exp_ready != 2'b00) begin
      a = exp_ready[1] ? a1 : a0;
      d = exp_ready[1] ? d1 : d0;
      if (a == 5'd0) x0_exp++;
      else exp_q.push_back({a, d});
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("we", 64'(we), 64'd1);
      check("waddr", 64'(waddr), 64'(e[36:32]));
      check("wdata", 64'(wdata), 64'(e[31:0]));
    end else begin
      check("we_idle", 64'(we), 64'd0);
    end
    if (r) begin
      check("waddr_rst", 64'(waddr), 64'd0);
      check("wdata_rst", 64'(wdata), 64'd0);
    end
    check("x0cnt", 64'(cnt), 64'(x0_exp));
    check("satcnt", 64'(cnt_s), (x0_exp > 3) ? 64'd3 : 64'(x0_exp));
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    valid  = '0;
    addr   = '0;
    data   = '0;
    valid4 = '0;
    addr4  = '0;
    data4  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_we4", 64'(we4), 64'd0);
    check("rst_cnt_s", 64'(cnt_s), 64'd0);
    rst = 1'b0;

    // Single transfer, one-cycle latency, then idle.
    drive(1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b01, 1'b0);
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);

    // x0 writes from requester 1; the 2-bit counter instance must stick at 3.
    repeat (3) drive(1'b0, 2'b10, 5'd0, 5'd0, 32'h0, 32'h5555, 2'b10, 1'b0);
    check("x0cnt_3", 64'(cnt), 64'd3);
    check("satcnt_3", 64'(cnt_s), 64'd3);
    repeat (2) drive(1'b0, 2'b10, 5'd0, 5'd0, 32'h0, 32'h5555, 2'b10, 1'b0);
    check("x0cnt_5", 64'(cnt), 64'd5);
    check("satcnt_hold", 64'(cnt_s), 64'd3);

    // Leave pointer at 0, then reset with both valid: ready follows the old pointer, no write follows.
    drive(1'b0, 2'b01, 5'd4, 5'd0, 32'h44, 32'h0, 2'b01, 1'b0);
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'h11110000, 32'h22220000, 2'b10, 1'b1);
    check("post_rst_cnt", 64'(cnt), 64'd0);

    // Fair alternation starting at requester 0.
    drive(1'b0, 2'b11, 5'd1, 5'd2, 32'h11110000, 32'h22220000, 2'b01, 1'b1);
    drive(1'b0, 2'b11, 5'd1, 5'd2, 32'h11110001, 32'h22220001, 2'b10, 1'b1);
    drive(1'b0, 2'b11, 5'd1, 5'd2, 32'h11110002, 32'h22220002, 2'b01, 1'b1);
    drive(1'b0, 2'b11, 5'd1, 5'd2, 32'h11110003, 32'h22220003, 2'b10, 1'b1);

    // Requester 0 abandons a request while requester 1 holds the bus.
    drive(1'b0, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 2'b01, 1'b0);
    drive(1'b0, 2'b11, 5'd9, 5'd3, 32'h99, 32'h33, 2'b10, 1'b1);
    drive(1'b0, 2'b10, 5'd0, 5'd3, 32'h0, 32'h34, 2'b10, 1'b0);
    drive(1'b0, 2'b11, 5'd12, 5'd3, 32'hCC, 32'h35, 2'b01, 1'b1);
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // Four requesters, 1 and 3 valid, 2 idle: grants 1,3,1,3.
    valid4 = 4'b1010;
    addr4  = {5'd13, 5'd0, 5'd11, 5'd0};
    data4  = {32'hA3, 32'h0, 32'hA1, 32'h0};
    for (int i = 0; i < 4; i++) begin
      #1;
      check("q4_ready", 64'(ready4), (i % 2 == 0) ? 64'h2 : 64'h8);
      check("q4_busy", 64'(busy4), 64'd1);
      @(posedge clk);
      #1;
      check("q4_we", 64'(we4), 64'd1);
      check("q4_waddr", 64'(waddr4), (i % 2 == 0) ? 64'd11 : 64'd13);
      check("q4_wdata", 64'(wdata4), (i % 2 == 0) ? 64'hA1 : 64'hA3);
    end
    valid4 = 4'b0000;
    #1;
    check("q4_ready_idle", 64'(ready4), 64'd0);
    @(posedge clk);
    #1;
    check("q4_we_idle", 64'(we4), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
